// File: rtl/yrv_uart_pkg.sv
// Shared types and port_word field positions for the UART receive port.
package yrv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned NOT_EMPTY = 8;
  localparam int unsigned FULL      = 9;
  localparam int unsigned FERR      = 10;
  localparam int unsigned OVR       = 11;
  localparam int unsigned COUNT_LSB = 12;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO with simultaneous push/pop support; head reads as zero when empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: a full FIFO accepts a push only when a pop frees a slot.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    count   = count_q;
    head    = empty ? '0 : mem_q[rd_ptr_q];
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver feeding a byte FIFO, presented to the MCU as a 16-bit status/data word.
module uart_rx_port
  import yrv_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic        pop_req,
  input  logic        clr_err,
  output logic [15:0] port_word,
  output logic        byte_stb
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t      state_q;
  rx_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;

  logic           rx_meta_q;
  logic           rx_sync_q;
  logic           pop_meta_q;
  logic           pop_sync_q;
  logic           pop_prev_q;
  logic           pop_edge;

  logic           ferr_q;
  logic           ovr_q;
  logic           stb_q;

  logic           sample_data;
  logic           stop_sample;
  logic           push;
  logic           ferr_set;
  logic           ovr_set;
  logic           push_ok;

  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_head;

  // Two-flop synchronizers for the asynchronous pins plus the pop edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      pop_meta_q <= 1'b0;
      pop_sync_q <= 1'b0;
      pop_prev_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      pop_meta_q <= pop_req;
      pop_sync_q <= pop_meta_q;
      pop_prev_q <= pop_sync_q;
    end
  end

  assign pop_edge = pop_sync_q && !pop_prev_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == BIT_LAST && bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (cnt_q == BIT_LAST) state_d = rx_sync_q ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: sample strobes, push request and error events.
  always_comb begin
    sample_data = (state_q == DATA) && (cnt_q == BIT_LAST);
    stop_sample = (state_q == STOP) && (cnt_q == BIT_LAST);
    push        = stop_sample && rx_sync_q;
    ferr_set    = stop_sample && !rx_sync_q;
    ovr_set     = push && fifo_full && !pop_edge;
    push_ok     = push && (!fifo_full || pop_edge);
  end

  // Bit-time counter restarts on every state change and at each bit boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q || cnt_q == BIT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Data shifter, LSB first, with the sample index cleared on entry to DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      if (state_q != DATA) begin
        bit_idx_q <= '0;
      end else if (sample_data) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (sample_data) begin
        shift_q <= {rx_sync_q, shift_q[7:1]};
      end
    end
  end

  // Sticky error flags; clr_err wins over a same-cycle set. Strobe marks accepted pushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      if (clr_err) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (ferr_set) ferr_q <= 1'b1;
        if (ovr_set)  ovr_q  <= 1'b1;
      end
      stb_q <= push_ok;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop_edge),
    .wdata  (shift_q),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .head   (fifo_head)
  );

  // Assemble the MCU-visible word purely from registered state.
  always_comb begin
    port_word                   = '0;
    port_word[DATA_LSB +: 8]    = fifo_head;
    port_word[NOT_EMPTY]        = !fifo_empty;
    port_word[FULL]             = fifo_full;
    port_word[FERR]             = ferr_q;
    port_word[OVR]              = ovr_q;
    port_word[COUNT_LSB +: 4]   = 4'(fifo_count);
  end

  assign byte_stb = stb_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: expected words are queued at send time and
// checked by a monitor whenever byte_stb pulses; static states are checked inline.
module tb_uart_rx_port;

  logic        clk;
  logic        reset_n;
  logic        rx;
  logic        pop_req;
  logic        clr_err;
  logic [15:0] port_word;
  logic        byte_stb;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int exp_pushes = 0;
  logic [15:0] exp_q[$];

  uart_rx_port #(
    .CLK_FREQUENCY(16),
    .BAUD         (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .pop_req  (pop_req),
    .clr_err  (clr_err),
    .port_word(port_word),
    .byte_stb (byte_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (byte_stb) begin
      stb_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_stb: got word %h expected no strobe", port_word);
      end else begin
        check("stb_word", {16'h0, port_word}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic expect_push(input logic [15:0] w);
    exp_q.push_back(w);
    exp_pushes++;
  endtask

  // Called right after a negedge; returns 160 cycles later with rx left at the stop value.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_once(input int hold);
    pop_req = 1'b1;
    repeat (hold) @(negedge clk);
    pop_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    pop_req = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_word", {16'h0, port_word}, 32'h0000);
    check("reset_stb", {31'h0, byte_stb}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte and pop latency.
    expect_push(16'h11A5);
    send_byte(8'hA5, 1'b1);
    check("a5_word", {16'h0, port_word}, 32'h11A5);
    check("a5_stb_once", stb_cnt, 1);
    pop_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pop_latency_early", {16'h0, port_word}, 32'h11A5);
    @(negedge clk);
    check("pop_latency_3", {16'h0, port_word}, 32'h0000);
    repeat (2) @(negedge clk);
    pop_req = 1'b0;
    repeat (4) @(negedge clk);

    // Glitch on the line.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_word", {16'h0, port_word}, 32'h0000);
    check("glitch_no_stb", stb_cnt, 1);

    // Frame error followed by a held-low line, then a good byte.
    send_byte(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    check("ferr_word", {16'h0, port_word}, 32'h0400);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    expect_push(16'h1511);
    send_byte(8'h11, 1'b1);
    check("ferr_then_byte", {16'h0, port_word}, 32'h1511);
    clear_errors();
    check("ferr_cleared", {16'h0, port_word}, 32'h1111);
    pop_once(3);
    check("ferr_drained", {16'h0, port_word}, 32'h0000);

    // Overrun: five bytes into a four-deep FIFO.
    expect_push(16'h1101);
    send_byte(8'h01, 1'b1);
    expect_push(16'h2101);
    send_byte(8'h02, 1'b1);
    expect_push(16'h3101);
    send_byte(8'h03, 1'b1);
    expect_push(16'h4301);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    check("ovr_word", {16'h0, port_word}, 32'h4B01);
    pop_once(20);
    check("ovr_pop1_held", {16'h0, port_word}, 32'h3902);
    pop_once(3);
    check("ovr_pop2", {16'h0, port_word}, 32'h2903);
    pop_once(3);
    check("ovr_pop3", {16'h0, port_word}, 32'h1904);
    pop_once(3);
    check("ovr_pop4_empty", {16'h0, port_word}, 32'h0800);
    pop_once(3);
    check("pop_empty_ignored", {16'h0, port_word}, 32'h0800);
    clear_errors();
    check("ovr_cleared", {16'h0, port_word}, 32'h0000);

    // Fill, then land a pop edge on the stop-sample cycle of a fifth byte.
    expect_push(16'h1110);
    send_byte(8'h10, 1'b1);
    expect_push(16'h2110);
    send_byte(8'h11, 1'b1);
    expect_push(16'h3110);
    send_byte(8'h12, 1'b1);
    expect_push(16'h4310);
    send_byte(8'h13, 1'b1);
    expect_push(16'h4311);
    fork
      send_byte(8'h14, 1'b1);
      begin
        repeat (152) @(negedge clk);
        pop_req = 1'b1;
      end
    join
    check("simul_word", {16'h0, port_word}, 32'h4311);
    pop_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of 0xF0 after its low nibble.
    rx = 1'b0;
    repeat (16 + 64) @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_word", {16'h0, port_word}, 32'h0000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    expect_push(16'h115A);
    send_byte(8'h5A, 1'b1);
    check("after_reset_word", {16'h0, port_word}, 32'h115A);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("stb_total", stb_cnt, exp_pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
